// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters and long-latency flags
// that stall decode on unforwardable RAW hazards, plus a flush/drain sequencer.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle writeback release the stall early.
module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 2,
  parameter int TOT_W  = 6
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              sb_issue_valid_in,
  input  logic [ADDR_W-1:0] sb_issue_rd_addr_in,
  input  logic              sb_issue_long_in,
  input  logic              sb_wb_valid_in,
  input  logic [ADDR_W-1:0] sb_wb_rd_addr_in,
  input  logic              sb_dec_valid_in,
  input  logic [ADDR_W-1:0] sb_dec_ra_addr_in,
  input  logic [ADDR_W-1:0] sb_dec_rb_addr_in,
  input  logic              sb_flush_in,
  output logic              sb_stall_out,
  output logic [TOT_W-1:0]  sb_pending_out,
  output logic              sb_err_out
);
  typedef enum logic [1:0] {S_RUN, S_STALL, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                      state_q;
  logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0]            long_q, long_d;
  logic [TOT_W-1:0]            tot_q, tot_d;
  logic                        err_q, err_d;

  logic iss_eff, wb_eff, same, ovf, unf, inc, dec;
  logic dep_a, dep_b, dep;

  // Issue is dropped while draining; writebacks always retire.
  assign iss_eff = sb_issue_valid_in && (sb_issue_rd_addr_in != '0) && (state_q != S_DRAIN);
  assign wb_eff  = sb_wb_valid_in && (sb_wb_rd_addr_in != '0);
  assign same    = iss_eff && wb_eff && (sb_issue_rd_addr_in == sb_wb_rd_addr_in);
  assign ovf     = iss_eff && !same && (cnt_q[sb_issue_rd_addr_in] == CNT_MAX);
  assign unf     = wb_eff && !same && (cnt_q[sb_wb_rd_addr_in] == '0);
  assign inc     = iss_eff && !same && !ovf;
  assign dec     = wb_eff && !same && !unf;

  always_comb begin
    cnt_d  = cnt_q;
    long_d = long_q;
    if (inc) cnt_d[sb_issue_rd_addr_in] = cnt_q[sb_issue_rd_addr_in] + CNT_W'(1);
    if (iss_eff) long_d[sb_issue_rd_addr_in] = long_q[sb_issue_rd_addr_in] | sb_issue_long_in;
    if (dec) begin
      cnt_d[sb_wb_rd_addr_in] = cnt_q[sb_wb_rd_addr_in] - CNT_W'(1);
      if (cnt_q[sb_wb_rd_addr_in] == CNT_W'(1)) long_d[sb_wb_rd_addr_in] = 1'b0;
    end
    cnt_d[0]  = '0;
    long_d[0] = 1'b0;
  end

  always_comb begin
    tot_d = tot_q;
    if (inc && !dec && (tot_q != '1))      tot_d = tot_q + TOT_W'(1);
    else if (dec && !inc && (tot_q != '0)) tot_d = tot_q - TOT_W'(1);
    err_d = err_q | ovf | unf;
  end

  always_comb begin
    dep_a = (sb_dec_ra_addr_in != '0) && (cnt_q[sb_dec_ra_addr_in] != '0) && long_q[sb_dec_ra_addr_in];
    dep_b = (sb_dec_rb_addr_in != '0) && (cnt_q[sb_dec_rb_addr_in] != '0) && long_q[sb_dec_rb_addr_in];
`ifdef SB_WB_BYPASS_EN
    if (sb_wb_valid_in && (sb_wb_rd_addr_in == sb_dec_ra_addr_in)) dep_a = 1'b0;
    if (sb_wb_valid_in && (sb_wb_rd_addr_in == sb_dec_rb_addr_in)) dep_b = 1'b0;
`endif
    dep = sb_dec_valid_in && (dep_a || dep_b);
  end

  assign sb_stall_out   = (state_q == S_DRAIN) ? 1'b1 : dep;
  assign sb_pending_out = tot_q;
  assign sb_err_out     = err_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q  <= '0;
      long_q <= '0;
      tot_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      long_q <= long_d;
      tot_q  <= tot_d;
      err_q  <= err_d;
    end
  end

  // Flush wins over dependency; DRAIN exits once the registered total is empty.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (sb_flush_in)  state_q <= S_DRAIN;
          else if (dep)     state_q <= S_STALL;
        end
        S_STALL: begin
          if (sb_flush_in)  state_q <= S_DRAIN;
          else if (!dep)    state_q <= S_RUN;
        end
        S_DRAIN: begin
          if (!sb_flush_in && (tot_q == '0)) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard/flush/overflow scenarios and random traffic
// checked every cycle against a count-per-register model.
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv, il, wv, dv, fl;
  logic [4:0] ird, wrd, ra, rb;
  logic       stall, err;
  logic [5:0] pend;

  int errors = 0;
  int checks = 0;

  // Model: outstanding writes per register, long flag, sticky error, draining flag.
  int cnt[32];
  bit lng[32];
  bit m_err, m_drain;

  reg_scoreboard dut (
    .clock_in(clk), .reset_in(rst),
    .sb_issue_valid_in(iv), .sb_issue_rd_addr_in(ird), .sb_issue_long_in(il),
    .sb_wb_valid_in(wv), .sb_wb_rd_addr_in(wrd),
    .sb_dec_valid_in(dv), .sb_dec_ra_addr_in(ra), .sb_dec_rb_addr_in(rb),
    .sb_flush_in(fl),
    .sb_stall_out(stall), .sb_pending_out(pend), .sb_err_out(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pend();
    int s = 0;
    for (int r = 1; r < 32; r++) s += cnt[r];
    return s;
  endfunction

  function automatic bit m_dep(logic [4:0] a);
    bit d;
    d = (a != 0) && (cnt[a] > 0) && lng[a];
`ifdef SB_WB_BYPASS_EN
    if (wv && (wrd == a)) d = 1'b0;
`endif
    return d;
  endfunction

  function automatic bit m_stall();
    return m_drain || (dv && (m_dep(ra) || m_dep(rb)));
  endfunction

  always @(posedge clk or posedge rst) begin
    bit iss, wb;
    int tot0;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin cnt[r] = 0; lng[r] = 1'b0; end
      m_err   = 1'b0;
      m_drain = 1'b0;
    end else begin
      tot0 = m_pend();
      iss  = iv && (ird != 0) && !m_drain;
      wb   = wv && (wrd != 0);
      if (iss && wb && (ird == wrd)) begin
        lng[ird] = lng[ird] | il;
      end else begin
        if (iss) begin
          if (cnt[ird] == 3) m_err = 1'b1; else cnt[ird]++;
          lng[ird] = lng[ird] | il;
        end
        if (wb) begin
          if (cnt[wrd] == 0) m_err = 1'b1;
          else begin
            cnt[wrd]--;
            if (cnt[wrd] == 0) lng[wrd] = 1'b0;
          end
        end
      end
      m_drain = m_drain ? (fl || (tot0 != 0)) : fl;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_stall", 32'(stall), 32'(m_stall()));
      chk("model_pending", 32'(pend), 32'(m_pend()));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic idle();
    iv = 0; ird = 0; il = 0; wv = 0; wrd = 0; dv = 0; ra = 0; rb = 0; fl = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; nxt(); rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    idle();
    rst = 1'b1;
    at_neg();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_err", 32'(err), 0);
    nxt(); rst = 1'b0;

    // long rd=5 hazard
    iv = 1; ird = 5; il = 1; nxt();
    idle(); dv = 1; ra = 5; at_neg();
    chk("t1_stall", 32'(stall), 1);
    chk("t1_pend", 32'(pend), 1);
    nxt();
    wv = 1; wrd = 5; at_neg();
`ifdef SB_WB_BYPASS_EN
    chk("t1_wb_stall", 32'(stall), 0);
`else
    chk("t1_wb_stall", 32'(stall), 1);
`endif
    nxt();
    wv = 0; at_neg();
    chk("t1_rel_stall", 32'(stall), 0);
    chk("t1_rel_pend", 32'(pend), 0);
    nxt();

    // short rd=7 is forwardable
    idle(); iv = 1; ird = 7; nxt();
    idle(); dv = 1; rb = 7; at_neg();
    chk("t2_stall", 32'(stall), 0);
    chk("t2_pend", 32'(pend), 1);
    nxt();
    idle(); wv = 1; wrd = 7; nxt();
    idle(); at_neg();
    chk("t2_pend0", 32'(pend), 0);
    nxt();

    // x0 ignored everywhere
    idle(); iv = 1; ird = 0; il = 1; wv = 1; wrd = 0; nxt();
    idle(); dv = 1; ra = 0; at_neg();
    chk("t3_stall", 32'(stall), 0);
    chk("t3_pend", 32'(pend), 0);
    chk("t3_err", 32'(err), 0);
    nxt();

    // counter saturation
    idle(); iv = 1; ird = 3; repeat (4) nxt();
    idle(); at_neg();
    chk("t4_err", 32'(err), 1);
    chk("t4_pend", 32'(pend), 3);
    nxt();
    wv = 1; wrd = 3; repeat (3) nxt();
    idle(); at_neg();
    chk("t4_pend0", 32'(pend), 0);
    chk("t4_err_sticky", 32'(err), 1);
    nxt();
    do_reset(); at_neg();
    chk("t4_err_clr", 32'(err), 0);
    nxt();

    // flush / drain
    idle(); iv = 1; ird = 4; il = 1; nxt();
    ird = 6; nxt();
    idle(); fl = 1; nxt();
    idle(); iv = 1; ird = 8; at_neg();
    chk("t5_drain_stall", 32'(stall), 1);
    chk("t5_drain_pend", 32'(pend), 2);
    nxt();
    idle(); wv = 1; wrd = 4; at_neg();
    chk("t5_iss_ignored", 32'(pend), 2);
    chk("t5_stall_a", 32'(stall), 1);
    nxt();
    wrd = 6; at_neg();
    chk("t5_pend1", 32'(pend), 1);
    chk("t5_stall_b", 32'(stall), 1);
    nxt();
    idle(); at_neg();
    chk("t5_pend0", 32'(pend), 0);
    chk("t5_stall_c", 32'(stall), 1);
    nxt();
    at_neg();
    chk("t5_run_stall", 32'(stall), 0);
    nxt();

    // same-cycle issue+wb to rd=9
    idle(); iv = 1; ird = 9; nxt();
    wv = 1; wrd = 9; at_neg();
    chk("t6_pend_a", 32'(pend), 1);
    nxt();
    idle(); at_neg();
    chk("t6_pend_b", 32'(pend), 1);
    nxt();
    wv = 1; wrd = 9; nxt();
    idle(); at_neg();
    chk("t6_pend0", 32'(pend), 0);
    chk("t6_err", 32'(err), 0);
    nxt();

    // reset mid-STALL
    iv = 1; ird = 10; il = 1; nxt();
    idle(); dv = 1; ra = 10; at_neg();
    chk("t6_stall_a", 32'(stall), 1);
    nxt();
    at_neg();
    chk("t6_stall_b", 32'(stall), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_pend", 32'(pend), 0);
    chk("t6_rst_err", 32'(err), 0);
    nxt(); rst = 1'b0;
    idle(); nxt();

    // random traffic on x0..x7
    for (int i = 0; i < 3000; i++) begin
      iv  = ($urandom_range(0, 99) < 45);
      ird = 5'($urandom_range(0, 7));
      il  = 1'($urandom_range(0, 1));
      wv  = ($urandom_range(0, 99) < 40);
      wrd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) begin
        j = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) begin
          if (cnt[(j + k) % 8] > 0) begin
            wrd = 5'((j + k) % 8);
            break;
          end
        end
      end
      dv = ($urandom_range(0, 99) < 70);
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 399) == 0) do_reset();
      else nxt();
    end

    idle(); nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register tracker of in-flight destination writes. It is the producer-side counterpart to the forwarding unit's consumer-side compare.
- Records every rd issued from IS and clears it on writeback.
- Stalls decode when an RS1/RS2 source depends on a pending long-latency result that forwarding cannot supply.
- Provides a flush/drain sequence so decode restarts only after outstanding writes retire.

Parameters:
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers (x0 never tracked).
- CNT_W, 2, width of the per-register outstanding-write counter; max count = 2^CNT_W-1.
- TOT_W, 6, width of the global outstanding-write counter.

Ports:
- clock_in  in  1  core clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- sb_issue_valid_in  in  1  instruction with rd leaves IS this cycle.
- sb_issue_rd_addr_in  in  ADDR_W  rd of issuing instruction.
- sb_issue_long_in  in  1  result is not forwardable next cycle (load/mul/div).
- sb_wb_valid_in  in  1  writeback to register file this cycle.
- sb_wb_rd_addr_in  in  ADDR_W  rd being written back.
- sb_dec_valid_in  in  1  valid instruction in ID.
- sb_dec_ra_addr_in  in  ADDR_W  RS1 in ID.
- sb_dec_rb_addr_in  in  ADDR_W  RS2 in ID.
- sb_flush_in  in  1  pipeline flush request (one-cycle pulse).
- sb_stall_out  out  1  hold ID/IF this cycle.
- sb_pending_out  out  TOT_W  total outstanding writes.
- sb_err_out  out  1  sticky: counter overflow or underflow.

Behaviour:
- Reset (async, reset_in=1): all counters 0, all long bits 0, state RUN, sb_stall_out=0, sb_pending_out=0, sb_err_out=0.
- Per register r≠0: cnt[r] (CNT_W) and long[r].
  - Issue to r only: cnt+1; long[r] set if sb_issue_long_in=1, otherwise unchanged.
  - Wb to r only: cnt-1; long[r] cleared when cnt reaches 0.
  - Issue and wb to same r in the same cycle: cnt unchanged; long[r] = sb_issue_long_in OR long[r].
- Address 0 is ignored on issue, wb and decode.
- Overflow: issue with cnt=max → cnt saturates, sb_err_out set.
- Underflow: wb with cnt=0 → cnt stays 0, sb_err_out set.
- sb_err_out clears only on reset.
- Global counter tot: +1 on effective issue, -1 on effective wb, both in the same cycle → no change. sb_pending_out = tot (registered).
- Dependency (combinational from registered state): dep = sb_dec_valid_in AND ((ra≠0 AND cnt[ra]>0 AND long[ra]) OR (rb≠0 AND cnt[rb]>0 AND long[rb])).
- Same-cycle wb does not release dep; the release is seen the following cycle.
- FSM states and transitions:
  - RUN: sb_stall_out=dep. dep=1 → STALL. sb_flush_in=1 → DRAIN, with priority over dep.
  - STALL: sb_stall_out=dep. dep=0 → RUN. sb_flush_in=1 → DRAIN.
  - DRAIN: sb_stall_out=1 unconditionally; issue inputs ignored; wb still processed. tot=0 → RUN next cycle, with stall deasserted in that RUN cycle. A flush arriving in DRAIN stays in DRAIN.
- Latency: issue/wb visible in counters and stall one cycle after the input edge.
- Reset mid-DRAIN or mid-STALL returns to RUN with all state cleared immediately.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a wb in the current cycle to register r masks r from the dep equation in that same cycle, so the stall releases 1 cycle earlier. In DRAIN, tot=1 with wb_valid exits to RUN at the same edge as without the macro; no change there.
- Undefined: behaviour exactly as above, with no same-cycle release.

Test Plan:
- Issue long rd=5; next cycle decode ra=5 → stall=1; wb rd=5 → stall=0 one cycle later (macro off) or the same cycle (macro on).
- Issue short rd=7; decode rb=7 → stall=0; pending=1; wb rd=7 → pending=0.
- Issue long rd=0; decode ra=0 → stall=0, pending=0, err=0.
- Four issues to rd=3 with no wb (CNT_W=2) → cnt saturates at 3, err=1 and stays 1 until reset.
- Two long issues outstanding, flush pulse → stall=1 through both wbs; stall=0 the cycle after pending reaches 0; an issue asserted during DRAIN leaves pending unchanged.
- Issue and wb to rd=9 in the same cycle with cnt[9]=1 → cnt stays 1, pending unchanged; assert reset mid-STALL → stall=0, pending=0 immediately.
